// File: rtl/dmux_sched_if.sv
// Handshake bundle between the word producer, the scheduler and the 1:4 demux fan-out.
// Latency: none, this is only a signal grouping.
// Backpressure: carries per-channel out_ready back to the producer as in_ready.
interface dmux_sched_if #(
  parameter int WIDTH = 8
);
  logic                 Enable;
  logic [3:0]           chan_en;
  logic [WIDTH-1:0]     Data_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*WIDTH-1:0]   O;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [1:0]           S;
  logic                 busy;
  logic [7:0]           beat;

  // Producer / consumer side (drives control and data, observes the scheduler)
  modport master (
    output Enable, chan_en, Data_in, in_valid, out_ready,
    input  in_ready, O, out_valid, S, busy, beat
  );

  // Scheduler side
  modport slave (
    input  Enable, chan_en, Data_in, in_valid, out_ready,
    output in_ready, O, out_valid, S, busy, beat
  );
endinterface

// File: rtl/dmux_sched.sv
// Round-robin burst scheduler steering one word stream onto one of four lanes.
// Latency: data/valid/ready are combinational; 1 arbitration cycle between bursts.
// Backpressure: in_ready follows out_ready of the granted lane; bursts never truncate.
module dmux_sched #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dmux_sched_if.slave  bus
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_sel;
  logic [1:0]         w_sel_nxt;
  logic [1:0]         r_last;
  logic [1:0]         w_last_nxt;
  logic [7:0]         r_beat;
  logic [7:0]         w_beat_nxt;

  logic               w_xfer;
  logic               w_grant_vld;
  logic [1:0]         w_grant;
  logic [1:0]         w_idx;

  logic [4*WIDTH-1:0] w_o;
  logic [3:0]         w_out_valid;
  logic               w_in_ready;

  // Rotating first-set search: last+1, last+2, last+3, then last itself
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = r_last;
    w_idx       = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_grant_vld && bus.chan_en[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  assign w_xfer = (r_state == ST_XFER) && bus.in_valid && bus.out_ready[r_sel];

  // Next-state: grant in ARB, count accepted beats in XFER, hold otherwise
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    case (r_state)
      ST_ARB: begin
        if (bus.Enable && w_grant_vld) begin
          w_state_nxt = ST_XFER;
          w_sel_nxt   = w_grant;
          w_last_nxt  = w_grant;
          w_beat_nxt  = 8'd0;
        end
      end
      ST_XFER: begin
        if (w_xfer) begin
          if (r_beat == 8'(BURST - 1)) begin
            w_state_nxt = ST_ARB;
            w_beat_nxt  = 8'd0;
          end else begin
            w_beat_nxt  = r_beat + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  // State register; last starts at 3 so the first search begins at channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_beat  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Demux datapath: only the granted lane sees data/valid, others forced to 0
  always_comb begin
    w_o         = '0;
    w_out_valid = '0;
    w_in_ready  = 1'b0;
    if (r_state == ST_XFER) begin
      w_out_valid[r_sel]          = bus.in_valid;
      w_o[r_sel*WIDTH +: WIDTH]   = bus.Data_in;
      w_in_ready                  = bus.out_ready[r_sel];
    end
  end

  assign bus.O         = w_o;
  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = w_in_ready;
  assign bus.S         = r_sel;
  assign bus.busy      = (r_state == ST_XFER);
  assign bus.beat      = r_beat;

endmodule

// File: tb/tb_dmux_sched.sv
// Bench for dmux_sched: two instances (BURST=4 and BURST=1) fed identical stimulus.
// Expected outputs come from a burst-level model of grant/count behaviour.
// Outputs are sampled shortly after the falling edge, inputs change on the falling edge.
module tb_dmux_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [3:0]   chan_en;
  logic [W-1:0] data_in;
  logic         in_valid;
  logic [3:0]   out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmux_sched_if #(.WIDTH(W)) bus4 ();
  dmux_sched_if #(.WIDTH(W)) bus1 ();

  assign bus4.Enable    = enable;
  assign bus4.chan_en   = chan_en;
  assign bus4.Data_in   = data_in;
  assign bus4.in_valid  = in_valid;
  assign bus4.out_ready = out_ready;
  assign bus1.Enable    = enable;
  assign bus1.chan_en   = chan_en;
  assign bus1.Data_in   = data_in;
  assign bus1.in_valid  = in_valid;
  assign bus1.out_ready = out_ready;

  dmux_sched #(.WIDTH(W), .BURST(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  dmux_sched #(.WIDTH(W), .BURST(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Burst-level model: granted channel, words delivered so far, last grant
  bit m_busy [2];
  int m_ch   [2];
  int m_cnt  [2];
  int m_last [2];
  int burst_of [2] = '{4, 1};

  function automatic void model_reset(int d);
    m_busy[d] = 1'b0;
    m_ch[d]   = 0;
    m_cnt[d]  = 0;
    m_last[d] = 3;
  endfunction

  function automatic bit model_xfer(int d);
    return m_busy[d] && in_valid && out_ready[m_ch[d]];
  endfunction

  function automatic void model_step(int d);
    bit found;
    int c;
    found = 1'b0;
    if (!rst_n) begin
      model_reset(d);
    end else if (!m_busy[d]) begin
      if (enable) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last[d] + k) % 4;
          if (!found && chan_en[c]) begin
            found     = 1'b1;
            m_ch[d]   = c;
            m_last[d] = c;
            m_cnt[d]  = 0;
            m_busy[d] = 1'b1;
          end
        end
      end
    end else if (model_xfer(d)) begin
      m_cnt[d] = m_cnt[d] + 1;
      if (m_cnt[d] == burst_of[d]) begin
        m_cnt[d]  = 0;
        m_busy[d] = 1'b0;
      end
    end
  endfunction

  // {S, busy, in_ready, out_valid, beat, O}
  function automatic logic [47:0] exp_vec(int d);
    logic [3:0]  ov;
    logic [31:0] o;
    logic        ir;
    logic [1:0]  s;
    logic [7:0]  b;
    ov = '0;
    o  = '0;
    ir = 1'b0;
    s  = 2'(m_ch[d]);
    b  = 8'(m_cnt[d]);
    if (m_busy[d]) begin
      ov[m_ch[d]]        = in_valid;
      o[m_ch[d]*8 +: 8]  = data_in;
      ir                 = out_ready[m_ch[d]];
    end
    return {s, m_busy[d], ir, ov, b, o};
  endfunction

  function automatic logic [47:0] act_vec(int d);
    if (d == 0)
      return {bus4.S, bus4.busy, bus4.in_ready, bus4.out_valid, bus4.beat, bus4.O};
    return {bus1.S, bus1.busy, bus1.in_ready, bus1.out_valid, bus1.beat, bus1.O};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    enable    = 1'b1;
    chan_en   = 4'hF;
    in_valid  = 1'b1;
    out_ready = 4'hF;
    data_in   = 8'hA5;
    #1 rst_n  = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== 48'h0) begin
        failures++;
        $display("FAIL reset dut%0d got=%h exp=%h", d, act_vec(d), 48'h0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int k;
    int xfers;
    k = 0;
    xfers = 0;
    do_reset();
    enable    = 1'b1;
    chan_en   = 4'hF;
    in_valid  = 1'b1;
    out_ready = 4'hF;
    for (int c = 0; c < 25; c++) begin
      data_in = 8'(8'h10 + k);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL round_robin dut%0d cyc%0d got=%h exp=%h", d, c, act_vec(d), exp_vec(d));
        end
      end
      if (bus4.in_valid && bus4.in_ready) xfers++;
      if (model_xfer(0)) k++;
      tick();
    end
    checks++;
    if (xfers !== 20) begin
      failures++;
      $display("FAIL rr_throughput got=%0d exp=%0d", xfers, 20);
    end
  endtask

  task automatic test_alt_mask();
    do_reset();
    enable  = 1'b1;
    chan_en = 4'b1010;
    for (int c = 0; c < 40; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 4'($urandom);
      data_in   = 8'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL alt_mask dut%0d cyc%0d got=%h exp=%h", d, c, act_vec(d), exp_vec(d));
        end
      end
      checks++;
      if ({bus4.out_valid[0], bus4.out_valid[2], bus4.O[7:0], bus4.O[23:16]} !== 18'h0) begin
        failures++;
        $display("FAIL alt_mask_idle_lanes cyc%0d got=%h exp=0", c,
                 {bus4.out_valid[0], bus4.out_valid[2], bus4.O[7:0], bus4.O[23:16]});
      end
      tick();
    end
  endtask

  task automatic test_ready_toggle();
    logic [6:0] pat;
    pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1
    do_reset();
    enable    = 1'b1;
    chan_en   = 4'b0100;
    in_valid  = 1'b1;
    out_ready = 4'h0;
    data_in   = 8'h33;
    tick();
    for (int c = 0; c < 7; c++) begin
      out_ready = {1'b0, pat[c], 2'b00};
      data_in   = 8'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL ready_toggle dut%0d cyc%0d got=%h exp=%h", d, c, act_vec(d), exp_vec(d));
        end
      end
      checks++;
      if (bus4.in_ready !== pat[c]) begin
        failures++;
        $display("FAIL ready_mirror cyc%0d got=%b exp=%b", c, bus4.in_ready, pat[c]);
      end
      tick();
    end
    enable = 1'b0;
    #1;
    checks++;
    if (bus4.busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_toggle_end got=%b exp=0", bus4.busy);
    end
  endtask

  task automatic test_mid_burst_disable();
    int guard;
    int xfers;
    xfers = 0;
    guard = 0;
    do_reset();
    enable    = 1'b1;
    chan_en   = 4'hF;
    in_valid  = 1'b1;
    out_ready = 4'hF;
    while (!(m_busy[0] && m_cnt[0] == 2) && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL mid_burst_reach got=%0d exp=<20", guard);
    end
    enable  = 1'b0;
    chan_en = 4'h0;
    for (int c = 0; c < 6; c++) begin
      data_in = 8'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL mid_disable dut%0d cyc%0d got=%h exp=%h", d, c, act_vec(d), exp_vec(d));
        end
      end
      if (bus4.in_valid && bus4.in_ready) xfers++;
      tick();
    end
    #1;
    checks++;
    if ({xfers[3:0], bus4.busy, bus4.in_ready} !== {4'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_disable_end got=%h exp=%h", {xfers[3:0], bus4.busy, bus4.in_ready}, 6'h08);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    enable    = 1'b1;
    chan_en   = 4'b0010;
    in_valid  = 1'b1;
    out_ready = 4'hF;
    data_in   = 8'h5A;
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== 48'h0) begin
        failures++;
        $display("FAIL mid_reset dut%0d got=%h exp=%h", d, act_vec(d), 48'h0);
      end
    end
    tick();
    rst_n   = 1'b1;
    chan_en = 4'hF;
    tick();
    #1;
    checks++;
    if ({bus4.S, bus4.busy, bus1.S, bus1.busy} !== {2'd0, 1'b1, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_grant got=%h exp=%h", {bus4.S, bus4.busy, bus1.S, bus1.busy}, 6'b001001);
    end
  endtask

  task automatic test_back_to_back_burst1();
    do_reset();
    enable    = 1'b1;
    chan_en   = 4'b0100;
    out_ready = 4'hF;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom_range(0, 4) != 0);
      data_in  = 8'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL burst1 dut%0d cyc%0d got=%h exp=%h", d, c, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (c % 7 == 0) begin
        enable  = 1'($urandom_range(0, 5) != 0);
        chan_en = 4'($urandom);
      end
      in_valid  = 1'($urandom);
      out_ready = 4'($urandom);
      data_in   = 8'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d got=%h exp=%h", d, c, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_alt_mask();
    test_ready_toggle();
    test_mid_burst_disable();
    test_mid_reset();
    test_back_to_back_burst1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmux_sched.md
# dmux_sched

Round-robin scheduler that shares a single upstream word stream between four downstream consumers by sequencing a 1:4 demultiplexer. It grants one enabled channel at a time, routes exactly BURST accepted words to it with valid/ready handshakes, then re-arbitrates. It sits between a single producer and the four-way demux fan-out, and drives the 2-bit select that the demux datapath uses.

## Interface
- WIDTH, 8: data word width in bits.
- BURST, 4: words delivered per grant; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Enable  in  1  global enable; sampled only in ARB state.
- chan_en  in  4  per-channel participation mask; bit i = channel i eligible.
- Data_in  in  WIDTH  upstream word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  upstream word accepted when in_valid & in_ready.
- O  out  4*WIDTH  lane i = O[i*WIDTH +: WIDTH]; non-selected lanes driven 0.
- out_valid  out  4  per-channel valid; at most one bit high.
- out_ready  in  4  per-channel ready.
- S  out  2  current grant / demux select (registered).
- busy  out  1  high in XFER.
- beat  out  8  accepted-word count within current burst (registered).

## Operation
- States: ARB, XFER. Reset state ARB.
- ARB: in_ready=0, out_valid=0, O=0. If Enable=1 and chan_en!=0, grant the first set chan_en bit searching last+1, last+2, last+3, last (mod 4); load S=grant, last=grant, beat=0, go to XFER. Otherwise stay in ARB, S holds.
- XFER: out_valid[S]=in_valid; lane S of O = Data_in; in_ready=out_ready[S]; all other lanes/valids 0. Combinational from registered S/state.
- Transfer = in_valid & out_ready[S] in XFER. On transfer, beat increments; on the transfer where beat==BURST-1, beat clears to 0 and state returns to ARB.
- Burst is never truncated: Enable or chan_en changes during XFER have no effect until ARB.
- No transfer in a cycle: hold state, beat, S. in_valid may drop mid-burst (bubble), no penalty.
- Single eligible channel: same channel re-granted every burst.
- Wrap: search pointer wraps 3->0. last resets to 3 so the first grant after reset goes to lowest enabled channel from 0.

## Timing
- Reset values: state=ARB, S=0, last=3, beat=0, busy=0, in_ready=0, out_valid=0, O=0.
- rst_n assertion mid-burst: immediate return to reset values; partially delivered burst abandoned, no further outputs.
- Arbitration latency: 1 cycle (ARB) between bursts; first XFER cycle is the cycle after Enable=1 sampled in ARB.
- Data path: zero latency from Data_in/in_valid to O/out_valid, and out_ready to in_ready (combinational).
- Peak throughput: BURST words per BURST+1 cycles.
- busy deasserts the cycle after the final beat transfer.

## Test plan
- Reset then Enable=1, chan_en=4'b1111, in_valid=1, out_ready=4'b1111, BURST=4 -> S sequence 0,1,2,3,0 with 4 transfers each and 1 ARB cycle between; Data_in 0x10..0x1F appear on lanes 0,0,0,0,1,1,1,1,... in order.
- chan_en=4'b1010 -> grants alternate 1,3,1,3; lanes 0 and 2 stay 0, out_valid[0]=out_valid[2]=0 throughout.
- Granted channel 2, out_ready[2] toggling 1,0,0,1,1,0,1 with in_valid=1 -> in_ready mirrors out_ready[2]; burst ends after 4th accepted word; beat never advances on ready=0 cycles.
- Mid-burst (beat=2): Enable->0 and chan_en->0 -> burst completes remaining 2 words, then stays in ARB with in_ready=0, busy=0.
- Mid-burst rst_n pulse low for 1 cycle -> all outputs 0 immediately, S=0; after release with chan_en=4'b1111 first grant is channel 0.
- BURST=1, chan_en=4'b0100 -> channel 2 re-granted every other cycle, one word per grant.
